// File: rtl/sys_arr_pkg.sv
// Shared definitions for the systolic-array output FIFO controller.
// Holds the array geometry (N elements per row / rows per tile, DW bits
// per element), the derived counter widths and the controller state type.
package sys_arr_pkg;

  localparam int N  = 4;
  localparam int DW = 16;
  // Counters must reach N (rows_in saturates at N), hence N+1 codes.
  localparam int CW = $clog2(N + 1);
  // Row index width inside a tile.
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ROW = 3'd1,
    SHIFT    = 3'd2,
    PRESENT  = 3'd3,
    DONE     = 3'd4
  } out_ctrl_state_t;

endpackage

// File: rtl/sysarr_row_serializer.sv
// Row serializer for the systolic-array output FIFO.
// Keeps a one-entry hold buffer for an accepted row and a shift register
// that feeds the FIFO one element per cycle, element 0 first.
// Ports:
//   clk, RST          clock, synchronous active-high reset
//   accept            row handshake this cycle: capture row_data into hold
//   row_data          N*DW row, element k at [k*DW +: DW]
//   load              move hold into the shift register (SHIFT entry edge)
//   shifting          controller is in SHIFT
//   hold_full         hold buffer occupied
//   fifo_shift        shift strobe to the output FIFO
//   fifo_shift_value  element pushed into the FIFO top slot
//   shift_last        final shift cycle of the current row
module sysarr_row_serializer
  import sys_arr_pkg::*;
(
  input  logic            clk,
  input  logic            RST,
  input  logic            accept,
  input  logic [N*DW-1:0] row_data,
  input  logic            load,
  input  logic            shifting,
  output logic            hold_full,
  output logic            fifo_shift,
  output logic [DW-1:0]   fifo_shift_value,
  output logic            shift_last
);

  logic [N*DW-1:0] hold_r;
  logic            hold_full_r;
  logic [N*DW-1:0] shreg_r;
  logic [CW-1:0]   shift_cnt_r;

  // Hold buffer: filled by the row handshake, emptied when moved to shreg.
  // accept and load are mutually exclusive because row_ready is low
  // whenever the hold buffer is full.
  always_ff @(posedge clk) begin
    if (RST) begin
      hold_r      <= {(N*DW){1'b0}};
      hold_full_r <= 1'b0;
    end else if (accept) begin
      hold_r      <= row_data;
      hold_full_r <= 1'b1;
    end else if (load) begin
      hold_full_r <= 1'b0;
    end
  end

  // Shift register and shift counter: load on SHIFT entry, then step right
  // one element per SHIFT cycle so the low element is always the next push.
  always_ff @(posedge clk) begin
    if (RST) begin
      shreg_r     <= {(N*DW){1'b0}};
      shift_cnt_r <= {CW{1'b0}};
    end else if (load) begin
      shreg_r     <= hold_r;
      shift_cnt_r <= {CW{1'b0}};
    end else if (shifting) begin
      shreg_r     <= shreg_r >> DW;
      shift_cnt_r <= shift_cnt_r + CW'(1);
    end
  end

  assign hold_full        = hold_full_r;
  assign fifo_shift       = shifting;
  assign fifo_shift_value = shifting ? shreg_r[DW-1:0] : {DW{1'b0}};
  assign shift_last       = shifting && (shift_cnt_r == CW'(N - 1));

endmodule

// File: rtl/sysarr_out_fifo_ctrl.sv
// Output FIFO sequencer for one N-row systolic-array result tile.
// Accepts rows over valid/ready, serialises each into the output FIFO with
// N shift pulses, then presents the assembled FIFO contents downstream with
// the row index, and pulses tile_done after the last row is taken.
// Ports:
//   clk, RST                     clock, synchronous active-high reset
//   start                        begin a tile (only looked at in IDLE)
//   row_valid/row_ready/row_data row intake handshake
//   fifo_shift/fifo_shift_value  FIFO shift strobe and pushed element
//   fifo_out                     FIFO contents
//   out_valid/out_ready          downstream handshake
//   out_data                     fifo_out pass-through
//   out_row                      row index of out_data within the tile
//   busy, tile_done              status
module sysarr_out_fifo_ctrl
  import sys_arr_pkg::*;
(
  input  logic            clk,
  input  logic            RST,
  input  logic            start,
  input  logic            row_valid,
  output logic            row_ready,
  input  logic [N*DW-1:0] row_data,
  output logic            fifo_shift,
  output logic [DW-1:0]   fifo_shift_value,
  input  logic [N*DW-1:0] fifo_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic [RW-1:0]   out_row,
  output logic            busy,
  output logic            tile_done
);

  out_ctrl_state_t state_r;
  out_ctrl_state_t state_nxt_s;
  logic [CW-1:0]   rows_in_r;
  logic [CW-1:0]   rows_out_r;
  logic            hold_full_s;
  logic            shift_last_s;
  logic            accept_s;
  logic            load_s;
  logic            shifting_s;
  logic            out_fire_s;

  // All handshake-facing outputs decode registered state only.
  assign row_ready  = ((state_r == WAIT_ROW) || (state_r == SHIFT) ||
                       (state_r == PRESENT)) && !hold_full_s &&
                      (rows_in_r < CW'(N));
  assign accept_s   = row_valid && row_ready;
  assign shifting_s = (state_r == SHIFT);
  assign out_valid  = (state_r == PRESENT);
  assign out_fire_s = out_valid && out_ready;
  assign out_row    = out_valid ? rows_out_r[RW-1:0] : {RW{1'b0}};
  assign out_data   = fifo_out;
  assign busy       = (state_r != IDLE);
  assign tile_done  = (state_r == DONE);
  // The hold-to-shreg transfer happens on every edge that enters SHIFT.
  assign load_s     = (state_nxt_s == SHIFT) && (state_r != SHIFT);

  sysarr_row_serializer u_ser (
    .clk              (clk),
    .RST              (RST),
    .accept           (accept_s),
    .row_data         (row_data),
    .load             (load_s),
    .shifting         (shifting_s),
    .hold_full        (hold_full_s),
    .fifo_shift       (fifo_shift),
    .fifo_shift_value (fifo_shift_value),
    .shift_last       (shift_last_s)
  );

  // Next-state logic for the tile sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = WAIT_ROW;
        else       state_nxt_s = IDLE;
      end
      WAIT_ROW: begin
        if (hold_full_s) state_nxt_s = SHIFT;
        else             state_nxt_s = WAIT_ROW;
      end
      SHIFT: begin
        if (shift_last_s) state_nxt_s = PRESENT;
        else              state_nxt_s = SHIFT;
      end
      PRESENT: begin
        if (out_ready) begin
          if (rows_out_r == CW'(N - 1)) state_nxt_s = DONE;
          else if (hold_full_s)         state_nxt_s = SHIFT;
          else                          state_nxt_s = WAIT_ROW;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Per-tile row counters, cleared as the tile finishes.
  always_ff @(posedge clk) begin
    if (RST || (state_r == DONE)) begin
      rows_in_r  <= {CW{1'b0}};
      rows_out_r <= {CW{1'b0}};
    end else begin
      if (accept_s)   rows_in_r  <= rows_in_r + CW'(1);
      if (out_fire_s) rows_out_r <= rows_out_r + CW'(1);
    end
  end

endmodule
